// File: rtl/a_plus_b_fifo_ctrl.sv
// Pairs the heads of two first-word-fall-through FIFOs and presents their
// width+1 bit sum through a one-deep valid/ready output register.
module a_plus_b_fifo_ctrl #(
  parameter int width     = 8,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_vld,
  input  logic [width-1:0]     a_data,
  output logic                 a_rdy,
  input  logic                 b_vld,
  input  logic [width-1:0]     b_data,
  output logic                 b_rdy,
  output logic                 a_push,
  output logic [width-1:0]     a_wdata,
  output logic                 a_pop,
  input  logic [width-1:0]     a_rdata,
  input  logic                 a_empty,
  input  logic                 a_full,
  output logic                 b_push,
  output logic [width-1:0]     b_wdata,
  output logic                 b_pop,
  input  logic [width-1:0]     b_rdata,
  input  logic                 b_empty,
  input  logic                 b_full,
  output logic                 sum_vld,
  output logic [width:0]       sum_data,
  input  logic                 sum_rdy,
  output logic [cnt_width-1:0] pair_cnt
);

  // state   | meaning
  // S_EMPTY | output register holds no valid result
  // S_HOLD  | sum_vld=1, result waiting for sum_rdy
  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t               r_state;
  logic [width:0]       r_sum_data;
  logic [cnt_width-1:0] r_pair_cnt;
  logic                 w_take;
  logic                 w_accept;
  logic [width:0]       w_sum;

  assign a_rdy   = ~a_full;
  assign b_rdy   = ~b_full;
  assign a_push  = a_vld & ~a_full & ~rst;
  assign b_push  = b_vld & ~b_full & ~rst;
  assign a_wdata = a_data;
  assign b_wdata = b_data;

  // Both heads are consumed together so the k-th A always meets the k-th B.
  assign w_take = ~a_empty & ~b_empty & ((r_state == S_EMPTY) | sum_rdy) & ~rst;
  assign a_pop  = w_take;
  assign b_pop  = w_take;

  assign w_sum    = {1'b0, a_rdata} + {1'b0, b_rdata};
  assign w_accept = (r_state == S_HOLD) & sum_rdy;

  assign sum_vld  = (r_state == S_HOLD);
  assign sum_data = r_sum_data;
  assign pair_cnt = r_pair_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_sum_data <= '0;
      r_pair_cnt <= '0;
    end else begin
      if (w_accept)
        r_pair_cnt <= r_pair_cnt + cnt_width'(1);
      // A take while the old result drains reloads in place: one result per cycle.
      if (w_take) begin
        r_sum_data <= w_sum;
        r_state    <= S_HOLD;
      end else if (w_accept) begin
        r_state    <= S_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_a_plus_b_fifo_ctrl.sv
// Directed bench for a_plus_b_fifo_ctrl with two depth-4 FWFT FIFO models
// and a queue scoreboard checked on every output handshake.
module tb_a_plus_b_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_vld, b_vld, a_rdy, b_rdy;
  logic [7:0]  a_data, b_data;
  logic        a_push, a_pop, a_empty, a_full;
  logic        b_push, b_pop, b_empty, b_full;
  logic [7:0]  a_wdata, a_rdata, b_wdata, b_rdata;
  logic        sum_vld, sum_rdy;
  logic [8:0]  sum_data;
  logic [15:0] pair_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  pend_a[$];
  logic [7:0]  pend_b[$];
  logic [15:0] m_cnt = 16'd0;

  a_plus_b_fifo_ctrl #(.width(8), .cnt_width(16)) dut (
    .clk(clk), .rst(rst),
    .a_vld(a_vld), .a_data(a_data), .a_rdy(a_rdy),
    .b_vld(b_vld), .b_data(b_data), .b_rdy(b_rdy),
    .a_push(a_push), .a_wdata(a_wdata), .a_pop(a_pop), .a_rdata(a_rdata),
    .a_empty(a_empty), .a_full(a_full),
    .b_push(b_push), .b_wdata(b_wdata), .b_pop(b_pop), .b_rdata(b_rdata),
    .b_empty(b_empty), .b_full(b_full),
    .sum_vld(sum_vld), .sum_data(sum_data), .sum_rdy(sum_rdy),
    .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  // FIFO A model
  logic [7:0] fa_mem [4];
  logic [2:0] fa_cnt;
  logic [1:0] fa_rp, fa_wp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_cnt <= 3'd0; fa_rp <= 2'd0; fa_wp <= 2'd0;
    end else begin
      if (a_push) begin fa_mem[fa_wp] <= a_wdata; fa_wp <= fa_wp + 2'd1; end
      if (a_pop) fa_rp <= fa_rp + 2'd1;
      fa_cnt <= fa_cnt + {2'd0, a_push} - {2'd0, a_pop};
    end
  end
  assign a_empty = (fa_cnt == 3'd0);
  assign a_full  = (fa_cnt == 3'd4);
  assign a_rdata = fa_mem[fa_rp];

  // FIFO B model
  logic [7:0] fb_mem [4];
  logic [2:0] fb_cnt;
  logic [1:0] fb_rp, fb_wp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_cnt <= 3'd0; fb_rp <= 2'd0; fb_wp <= 2'd0;
    end else begin
      if (b_push) begin fb_mem[fb_wp] <= b_wdata; fb_wp <= fb_wp + 2'd1; end
      if (b_pop) fb_rp <= fb_rp + 2'd1;
      fb_cnt <= fb_cnt + {2'd0, b_push} - {2'd0, b_pop};
    end
  end
  assign b_empty = (fb_cnt == 3'd0);
  assign b_full  = (fb_cnt == 3'd4);
  assign b_rdata = fb_mem[fb_rp];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic try_pair();
    logic [8:0] s;
    while (pend_a.size() != 0 && pend_b.size() != 0) begin
      s = {1'b0, pend_a.pop_front()} + {1'b0, pend_b.pop_front()};
      exp_q.push_back(s);
    end
  endtask

  // Scoreboard side: handshakes are evaluated mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      m_cnt = 16'd0;
    end else begin
      chk("pop_pair", {31'd0, a_pop}, {31'd0, b_pop});
      chk("pair_cnt_model", {16'd0, pair_cnt}, {16'd0, m_cnt});
      if (sum_vld && sum_rdy) begin
        if (exp_q.size() == 0)
          chk("unexpected_result", {23'd0, sum_data}, 32'hFFFF_FFFF);
        else
          chk("sum_data_sb", {23'd0, sum_data}, {23'd0, exp_q.pop_front()});
        m_cnt = m_cnt + 16'd1;
      end
    end
  end

  initial begin
    rst = 1'b1; a_vld = 1'b1; b_vld = 1'b1; a_data = 8'h11; b_data = 8'h22; sum_rdy = 1'b1;
    tick();
    chk("rst_sum_vld", {31'd0, sum_vld}, 32'd0);
    chk("rst_sum_data", {23'd0, sum_data}, 32'd0);
    chk("rst_pair_cnt", {16'd0, pair_cnt}, 32'd0);
    chk("rst_a_push", {31'd0, a_push}, 32'd0);
    chk("rst_b_push", {31'd0, b_push}, 32'd0);
    chk("rst_a_pop", {31'd0, a_pop}, 32'd0);
    tick();
    rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    tick();

    // basic pair 3+4
    a_vld = 1'b1; b_vld = 1'b1; a_data = 8'd3; b_data = 8'd4;
    pend_a.push_back(8'd3); pend_b.push_back(8'd4); try_pair();
    tick();
    a_vld = 1'b0; b_vld = 1'b0;
    chk("basic_vld_e1", {31'd0, sum_vld}, 32'd0);
    chk("basic_pop_e1", {31'd0, a_pop}, 32'd1);
    tick();
    chk("basic_vld_e2", {31'd0, sum_vld}, 32'd1);
    chk("basic_data_e2", {23'd0, sum_data}, 32'd7);
    tick();
    chk("basic_cnt_e3", {16'd0, pair_cnt}, 32'd1);
    chk("basic_vld_e3", {31'd0, sum_vld}, 32'd0);

    // overflow width
    a_vld = 1'b1; b_vld = 1'b1; a_data = 8'hFF; b_data = 8'hFF;
    pend_a.push_back(8'hFF); pend_b.push_back(8'hFF); try_pair();
    tick();
    a_vld = 1'b0; b_vld = 1'b0;
    tick();
    chk("ovf_vld", {31'd0, sum_vld}, 32'd1);
    chk("ovf_data", {23'd0, sum_data}, 32'h1FE);
    tick();
    tick();

    // one-sided data: A only, then B
    a_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = (i == 0) ? 8'd1 : (i == 1) ? 8'd2 : 8'd5;
      pend_a.push_back(a_data);
      tick();
      chk("oneside_a_pop", {31'd0, a_pop}, 32'd0);
      chk("oneside_vld", {31'd0, sum_vld}, 32'd0);
    end
    a_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("oneside_idle_pop", {31'd0, a_pop}, 32'd0);
      chk("oneside_idle_vld", {31'd0, sum_vld}, 32'd0);
    end
    b_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_data = (i == 0) ? 8'd10 : (i == 1) ? 8'd20 : 8'd30;
      pend_b.push_back(b_data); try_pair();
      tick();
    end
    b_vld = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("oneside_cnt", {16'd0, pair_cnt}, 32'd5);
    chk("oneside_drained", exp_q.size(), 32'd0);

    // async reset with a result pending
    sum_rdy = 1'b0;
    a_vld = 1'b1; b_vld = 1'b1; a_data = 8'd7; b_data = 8'd8;
    pend_a.push_back(8'd7); pend_b.push_back(8'd8); try_pair();
    tick();
    a_vld = 1'b0; b_vld = 1'b0;
    tick(); tick();
    chk("pre_rst_vld", {31'd0, sum_vld}, 32'd1);
    chk("pre_rst_cnt", {16'd0, pair_cnt}, 32'd5);
    #2;
    rst = 1'b1; a_vld = 1'b1; b_vld = 1'b1;
    exp_q.delete(); pend_a.delete(); pend_b.delete();
    #1;
    chk("mid_rst_vld", {31'd0, sum_vld}, 32'd0);
    chk("mid_rst_cnt", {16'd0, pair_cnt}, 32'd0);
    chk("mid_rst_data", {23'd0, sum_data}, 32'd0);
    chk("mid_rst_a_push", {31'd0, a_push}, 32'd0);
    chk("mid_rst_b_push", {31'd0, b_push}, 32'd0);
    chk("mid_rst_b_pop", {31'd0, b_pop}, 32'd0);
    tick();
    rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    tick();

    // backpressure then back-to-back drain
    sum_rdy = 1'b0;
    a_vld = 1'b1; b_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = (i == 0) ? 8'd1 : (i == 1) ? 8'd2 : 8'd40;
      b_data = (i == 0) ? 8'd1 : (i == 1) ? 8'd3 : 8'd50;
      pend_a.push_back(a_data); pend_b.push_back(b_data); try_pair();
      tick();
    end
    a_vld = 1'b0; b_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", {31'd0, sum_vld}, 32'd1);
      chk("bp_data", {23'd0, sum_data}, 32'd2);
      chk("bp_pop", {31'd0, a_pop}, 32'd0);
      tick();
    end
    sum_rdy = 1'b1;
    tick();
    chk("b2b_data1", {23'd0, sum_data}, 32'd5);
    chk("b2b_cnt1", {16'd0, pair_cnt}, 32'd1);
    tick();
    chk("b2b_data2", {23'd0, sum_data}, 32'd90);
    chk("b2b_cnt2", {16'd0, pair_cnt}, 32'd2);
    tick();
    chk("b2b_vld_end", {31'd0, sum_vld}, 32'd0);
    chk("b2b_cnt3", {16'd0, pair_cnt}, 32'd3);

    // full FIFO A with B empty
    a_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = 8'(100 + i);
      pend_a.push_back(a_data);
      tick();
    end
    a_data = 8'd104;
    chk("full_a_rdy", {31'd0, a_rdy}, 32'd0);
    chk("full_a_push", {31'd0, a_push}, 32'd0);
    tick();
    chk("full_a_push_hold", {31'd0, a_push}, 32'd0);
    chk("full_a_pop_hold", {31'd0, a_pop}, 32'd0);
    b_vld = 1'b1; b_data = 8'd1;
    pend_b.push_back(8'd1); try_pair();
    tick();
    b_vld = 1'b0;
    chk("full_take_pop", {31'd0, a_pop}, 32'd1);
    chk("full_take_rdy", {31'd0, a_rdy}, 32'd0);
    tick();
    chk("full_after_rdy", {31'd0, a_rdy}, 32'd1);
    chk("full_after_push", {31'd0, a_push}, 32'd1);
    pend_a.push_back(8'd104);
    tick();
    a_vld = 1'b0;
    b_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_data = 8'(2 + i);
      pend_b.push_back(b_data); try_pair();
      tick();
    end
    b_vld = 1'b0;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    tick(); tick();
    chk("final_drain", exp_q.size(), 32'd0);
    chk("final_cnt", {16'd0, pair_cnt}, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/a_plus_b_fifo_ctrl.md
A_PLUS_B_FIFO_CTRL -- requirements
Module: a_plus_b_fifo_ctrl

Interface
REQ-001 SHALL have parameter: width, 8, bit width of each operand.
REQ-002 SHALL have parameter: cnt_width, 16, width of the completed-pair counter.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: a_vld  in  1 / a_data  in  width / a_rdy  out  1  operand A upstream handshake.
REQ-006 SHALL have ports: b_vld  in  1 / b_data  in  width / b_rdy  out  1  operand B upstream handshake.
REQ-007 SHALL have ports: a_push  out  1 / a_wdata  out  width / a_pop  out  1 / a_rdata  in  width / a_empty  in  1 / a_full  in  1  control of external FIFO A (first-word fall-through read).
REQ-008 SHALL have ports b_push, b_wdata, b_pop, b_rdata, b_empty, b_full, identical to REQ-007 for FIFO B.
REQ-009 SHALL have ports: sum_vld  out  1 / sum_data  out  width+1 / sum_rdy  in  1  downstream result handshake.
REQ-010 SHALL have port: pair_cnt  out  cnt_width  number of results accepted downstream.

Function
REQ-011 SHALL drive a_rdy = ~a_full and a_push = a_vld & ~a_full & ~rst, combinationally; same for B.
REQ-012 SHALL pass a_data to a_wdata and b_data to b_wdata unmodified.
REQ-013 SHALL implement a 2-state FSM: S_EMPTY (output register invalid), S_HOLD (sum_vld=1, result pending).
REQ-014 SHALL define take = ~a_empty & ~b_empty & (state==S_EMPTY | sum_rdy) & ~rst.
REQ-015 SHALL assert a_pop and b_pop together, both equal to take; one-sided pop is forbidden.
REQ-016 SHALL, on a take, register sum_data <= a_rdata + b_rdata zero-extended to width+1 bits, with no overflow loss, and enter S_HOLD.
REQ-017 SHALL, in S_HOLD with sum_rdy=1 and no take, go to S_EMPTY and clear sum_vld; sum_data keeps its value.
REQ-018 SHALL, in S_HOLD with sum_rdy=1 and take, stay in S_HOLD and load the new sum in the same cycle, giving full throughput of one result per cycle.
REQ-019 SHALL hold sum_data and sum_vld stable while sum_vld=1 and sum_rdy=0.
REQ-020 SHALL drive sum_vld = (state==S_HOLD).
REQ-021 SHALL increment pair_cnt by 1 on each cycle with sum_vld & sum_rdy; it wraps from all-ones to 0.
REQ-022 SHALL have latency of 2 cycles from a_push/b_push of the last operand of a pair (edge N) to sum_vld high (after edge N+2), with FIFOs previously empty.
REQ-023 SHALL take no action while either FIFO is empty, regardless of the other FIFO's fill level; the non-empty FIFO keeps its data.
REQ-024 SHALL accept pushes into a full FIFO only through rdy=1; a full FIFO with a simultaneous take still shows rdy=0 in that cycle.
REQ-025 SHALL pair operands strictly in arrival order per FIFO, i.e. the k-th A with the k-th B.

Reset
REQ-026 SHALL, while rst=1, force state=S_EMPTY, sum_vld=0, sum_data=0 and pair_cnt=0 asynchronously.
REQ-027 SHALL hold a_push, b_push, a_pop and b_pop at 0 while rst=1, including reset asserted mid-transfer; the pending result is discarded.
REQ-028 SHALL start new operation on the first posedge after rst deasserts; FIFOs are reset by the same rst externally.

Verification
REQ-029 SHALL cover basic pair: push A=8'd3 at edge 0, push B=8'd4 at edge 0, sum_rdy=1 -> sum_vld=1, sum_data=9'd7 after edge 2; pair_cnt=1 after edge 3.
REQ-030 SHALL cover overflow width: A=8'hFF, B=8'hFF -> sum_data=9'h1FE.
REQ-031 SHALL cover one-sided data: push A=1, 2, 5 with no B -> a_pop=0 and sum_vld=0 throughout; then push B=10, 20, 30 -> sums 11, 22, 35 in order.
REQ-032 SHALL cover backpressure: sum_rdy=0 for 5 cycles with both FIFOs non-empty -> sum_data stable, pops=0; sum_rdy=1 -> one result per cycle back to back, pair_cnt advances by 1 per cycle.
REQ-033 SHALL cover full FIFO: fill A to a_full=1 with B empty -> a_rdy=0 and a_push=0 despite a_vld=1; push B -> a_rdy returns to 1 the cycle after the first take.
REQ-034 SHALL cover async reset: assert rst between posedges while sum_vld=1, pair_cnt=5 -> sum_vld=0 and pair_cnt=0 immediately, before the next posedge; pops/pushes=0 during reset.
